scroll_msg_buffer: RTL
======================

# scroll_msg_buffer

Upstream feeder for the four-digit seven-segment scroller. It accepts a message of character codes over a valid/ready write port and stores it in an internal buffer. On command, it shifts the message one character per scroll tick through a four-slot window (`first`..`fourth`), which feeds the digit multiplexer and segment decoder directly. Code 0 is blank, and the window is blank before and after the message.

## Interface
Parameters:
- `CHAR_W`, default 3: width of a character code; 0 = blank.
- `DEPTH`, default 16: message buffer entries; power of two, ≥ 4.
- `TICK_DIV`, default 100000000: clk cycles per scroll step (1 Hz at 100 MHz); ≥ 2.

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: reset is asynchronous and active-high.
- `wr_valid`  in  1: write character offered.
- `wr_ready`  out  1: buffer accepts write; transfer when `wr_valid && wr_ready`.
- `wr_char`  in  CHAR_W: character code.
- `wr_last`  in  1: qualifies the final character of the message.
- `start`  in  1: begin scrolling; honoured only in READY.
- `repeat_en`  in  1: sampled with `start`; 1 = loop the message forever.
- `first`, `second`, `third`, `fourth`  out  CHAR_W each: window; `first` = rightmost digit (newest).
- `busy`  out  1: high in SCROLL.
- `done`  out  1: one-cycle pulse at end of a non-repeating scroll.

## Operation
States are LOAD, READY and SCROLL. Reset enters LOAD with `len`=0, `idx`=0, prescaler=0, all window slots 0, `done`=0.

- **LOAD**
  - `wr_ready`=1.
  - Each accepted write stores `wr_char` at `buf[len]` and increments `len`.
  - Accepted write with `wr_last`=1, or the write that makes `len`==DEPTH, moves to READY.
  - `start` is ignored.
- **READY**
  - `wr_ready`=0; the buffer is frozen.
  - `start`=1 latches `repeat_en`, clears `idx` and the prescaler, and moves to SCROLL.
- **SCROLL**
  - `busy`=1, `wr_ready`=0.
  - The prescaler counts 0..TICK_DIV-1 and wraps. A step occurs on each edge where prescaler==TICK_DIV-1.
  - Step: `fourth`<=`third`, `third`<=`second`, `second`<=`first`, `first`<=(`idx`<`len` ? `buf[idx]` : 0), `idx`<=`idx`+1.
  - After step number `len`+4 the window is all blank.
    - If `repeat_en` was latched as 1: `idx`<=0 and scrolling continues; the next step loads `buf[0]`.
    - Otherwise: `done`=1 for one cycle, `len`<=0, state returns to LOAD.
- `idx` width: ceil(log2(DEPTH+5)) bits, no wrap before `len`+4.
- The buffer contents are not cleared; only `len` resets.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs, except `wr_ready`, which decodes state only.
- Write latency: a character is stored on the accepting edge. READY is entered on that same edge, so `wr_ready` is low in the following cycle.
- `start` sampled in READY → SCROLL, with `busy`=1 from the next cycle.
- The first step occurs TICK_DIV cycles after the SCROLL entry edge.
- `done` is high in the cycle after the final step edge; `wr_ready`=1 in that same cycle.
- `rst` asserted at any time, including mid-scroll or mid-write, forces every output and state register to its reset value immediately, without waiting for a clock edge.
- `wr_valid` outside LOAD is not accepted, and no data is stored.
- `start` in LOAD or SCROLL has no effect.
- `repeat_en` changes during SCROLL have no effect.

## Test plan
All scenarios use TICK_DIV=4, DEPTH=16, CHAR_W=3.
1. Reset: pulse `rst` mid-cycle → `first`..`fourth`=0, `busy`=0, `done`=0 asynchronously; `wr_ready`=1 after release.
2. Write codes 1,2,3,4,5,6 with `wr_last` on 6, then `start`, `repeat_en`=0. Required `{fourth,third,second,first}`:
   - step 1: 0,0,0,1
   - step 4: 1,2,3,4
   - step 6: 3,4,5,6
   - step 10: 0,0,0,0, with `done` pulsed exactly once and `wr_ready`=1 afterwards.
3. Write 17 characters with no `wr_last` → `wr_ready` falls after the 16th; the 17th is held off. Scrolling then shows `buf[15]` in `first` at step 16.
4. Two-character message 7,5 with `repeat_en`=1 → steps 1–2 give `first`=7 then 5; steps 3–6 shift it out to blank; step 7 gives `first`=7. `done` never asserts.
5. Assert `rst` at step 3 of scenario 2 → window 0 and state LOAD immediately. A new message then scrolls from blank.
6. Pulse `start` during LOAD, and `wr_valid` during SCROLL → no state change, no write accepted, window unaffected.

Source files
------------

// File: rtl/scroll_msg_buffer.sv
// scroll_msg_buffer
// Collects a message of character codes over a valid/ready port, then shifts
// it through a four-slot window, one character per scroll tick, so it can feed
// the seven-segment scroller. Code 0 is blank; the window is blank before and
// after the message.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_LOAD   | accepting message characters, wr_ready high
// S_READY  | message frozen, waiting for start
// S_SCROLL | shifting the message through the window on each tick
module scroll_msg_buffer #(
    parameter int CHAR_W   = 3,
    parameter int DEPTH    = 16,
    parameter int TICK_DIV = 100000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [CHAR_W-1:0] wr_char,
    input  logic              wr_last,
    input  logic              start,
    input  logic              repeat_en,
    output logic [CHAR_W-1:0] first,
    output logic [CHAR_W-1:0] second,
    output logic [CHAR_W-1:0] third,
    output logic [CHAR_W-1:0] fourth,
    output logic              busy,
    output logic              done
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LEN_W  = $clog2(DEPTH + 1);
    // idx runs up to len+4 without wrapping
    localparam int IDX_W  = $clog2(DEPTH + 5);
    localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PRE_W-1:0] PRE_TC   = PRE_W'(TICK_DIV - 1);
    localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_READY  = 2'd1,
        S_SCROLL = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [CHAR_W-1:0] msg_mem [DEPTH];
    logic [LEN_W-1:0]  len_q;
    logic [IDX_W-1:0]  idx_q;
    logic [PRE_W-1:0]  presc_q;
    logic              rpt_q;

    logic              wr_fire;
    logic              tick;
    logic              last_step;
    logic [IDX_W-1:0]  last_idx;
    logic [CHAR_W-1:0] step_char;

    assign wr_ready  = (state_q == S_LOAD);
    assign wr_fire   = wr_valid && wr_ready;
    assign tick      = (state_q == S_SCROLL) && (presc_q == PRE_TC);
    // step number len+4 is taken while idx still holds len+3
    assign last_idx  = IDX_W'(len_q) + IDX_W'(3);
    assign last_step = tick && (idx_q == last_idx);

    // Character entering the window: message entry, or blank past the end
    always_comb begin
        step_char = '0;
        if (idx_q < IDX_W'(len_q)) begin
            step_char = msg_mem[idx_q[ADDR_W-1:0]];
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD: begin
                if (wr_fire && (wr_last || (len_q == LEN_FULL))) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (start) begin
                    state_d = S_SCROLL;
                end
            end
            S_SCROLL: begin
                if (last_step && !rpt_q) begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // Message storage; contents survive a finished scroll, only len is cleared
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            msg_mem[len_q[ADDR_W-1:0]] <= wr_char;
        end
    end

    // Length, scroll position, prescaler, window and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q   <= '0;
            idx_q   <= '0;
            presc_q <= '0;
            rpt_q   <= 1'b0;
            first   <= '0;
            second  <= '0;
            third   <= '0;
            fourth  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            busy <= (state_d == S_SCROLL);
            case (state_q)
                S_LOAD: begin
                    if (wr_fire) begin
                        len_q <= len_q + LEN_W'(1);
                    end
                end
                S_READY: begin
                    if (start) begin
                        rpt_q   <= repeat_en;
                        idx_q   <= '0;
                        presc_q <= '0;
                    end
                end
                S_SCROLL: begin
                    presc_q <= tick ? '0 : presc_q + PRE_W'(1);
                    if (tick) begin
                        fourth <= third;
                        third  <= second;
                        second <= first;
                        first  <= step_char;
                        idx_q  <= (last_step && rpt_q) ? '0 : idx_q + IDX_W'(1);
                        if (last_step && !rpt_q) begin
                            done  <= 1'b1;
                            len_q <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
